// File: rtl/mul_div_unit_pkg.sv
// Shared RV32M definitions: funct3 codes, FSM state encodings, divider step
// count and a small decode helper used by the multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // DIV and REM are the signed divide ops; DIVU/REMU have funct3[0] set.
  function automatic logic is_signed_div(input logic [2:0] fn);
    return ~fn[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
//
// Handshake: the issuer raises START for one cycle with OP/A/B valid; the
// unit accepts it on the rising edge only when BUSY=0 (BUSY acts as the
// inverted ready). An accepted op leaves BUSY high until the cycle DONE is
// high; RESULT is valid while DONE=1 and held until the next accepted START.
// FLUSH aborts whatever is in flight and wins over START.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            START;
  logic [2:0]      OP;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            FLUSH;
  logic [XLEN-1:0] RESULT;
  logic            BUSY;
  logic            DONE;

  modport master (
    output START, OP, A, B, FLUSH,
    input  RESULT, BUSY, DONE
  );

  modport slave (
    input  START, OP, A, B, FLUSH,
    output RESULT, BUSY, DONE
  );
endinterface

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift {rem, quo} left by one, trial-subtract
// the divisor from the partial remainder and keep it when it does not borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic [XLEN-1:0] next_quo
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor always holds, so bit XLEN of the trial is a clean borrow flag.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, divisor};
    next_rem = shifted[XLEN-1:0];
    next_quo = {quo[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      next_rem = trial[XLEN-1:0];
      next_quo = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. MUL-family ops take a single product
// cycle; DIV/REM-family ops run a 32-step restoring divider on magnitudes and
// fix signs in FIN. Divide-by-zero and signed overflow skip straight to FIN.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  mul_div_unit_if.slave bus,
  output state_t        dbg_state
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   quo_q, rem_q, dvs_q;
  logic [5:0]        cnt_q;
  logic              q_neg_q, r_neg_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              div_signed, b_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              sext_a, sext_b;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   step_rem, step_quo;
  logic [XLEN-1:0]   fin_res;

  // Decode of the incoming op and operand conditioning for the divider.
  always_comb begin
    div_signed = is_signed_div(bus.OP);
    b_zero     = (bus.B == '0);
    div_ovf    = div_signed && (bus.A == MIN_NEG) && (bus.B == '1);
    a_mag      = (div_signed && bus.A[XLEN-1]) ? (-bus.A) : bus.A;
    b_mag      = (div_signed && bus.B[XLEN-1]) ? (-bus.B) : bus.B;
  end

  // Full product of the captured operands, extended per MULH/MULHSU/MULHU.
  always_comb begin
    sext_a = (op_q == FN_MULH) || (op_q == FN_MULHSU);
    sext_b = (op_q == FN_MULH);
    mul_a  = {{XLEN{sext_a & quo_q[XLEN-1]}}, quo_q};
    mul_b  = {{XLEN{sext_b & dvs_q[XLEN-1]}}, dvs_q};
    prod   = mul_a * mul_b;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  // Final result selection with sign restoration for signed divides.
  always_comb begin
    fin_res = rem_q;
    if (!op_q[2]) begin
      fin_res = (op_q == FN_MUL) ? quo_q : rem_q;
    end else if (op_q[1]) begin
      fin_res = r_neg_q ? (-rem_q) : rem_q;
    end else begin
      fin_res = q_neg_q ? (-quo_q) : quo_q;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; FLUSH returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          if (!bus.OP[2])          state_d = ST_MUL;
          else if (b_zero || div_ovf) state_d = ST_FIN;
          else                     state_d = ST_DIV;
        end
      end
      ST_MUL:  state_d = ST_FIN;
      ST_DIV:  if (cnt_q == 6'(DIV_STEPS - 1)) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.FLUSH) state_d = ST_IDLE;
  end

  // Datapath registers: operand capture, product/divide steps, result write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.FLUSH) begin
        cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.START) begin
              op_q    <= bus.OP;
              cnt_q   <= '0;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
              rem_q   <= '0;
              if (!bus.OP[2]) begin
                quo_q <= bus.A;
                dvs_q <= bus.B;
              end else if (b_zero) begin
                quo_q <= '1;
                rem_q <= bus.A;
              end else if (div_ovf) begin
                quo_q <= MIN_NEG;
              end else begin
                quo_q   <= a_mag;
                dvs_q   <= b_mag;
                q_neg_q <= div_signed && (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
                r_neg_q <= div_signed && bus.A[XLEN-1];
              end
            end
          end
          ST_MUL: begin
            {rem_q, quo_q} <= prod;
          end
          ST_DIV: begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + 6'd1;
          end
          ST_FIN: begin
            result_q <= fin_res;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.RESULT = result_q;
  assign bus.DONE   = done_q;
  assign bus.BUSY   = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule
